alu_sseg_scan: RTL and testbench

ALU_SSEG_SCAN -- requirements
Module: alu_sseg_scan

---
 rtl/alu_sseg_scan.sv | 112 +++++++++++
 tb/tb_alu_sseg_scan.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_sseg_scan.sv
// alu_sseg_scan: add/subtract two operands, convert to BCD by shift-add-3, show on a multiplexed 7-segment display
module alu_sseg_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic              sub,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              neg,
  output logic              ovf,
  output logic [6:0]        sseg,
  output logic [DIGITS-1:0] an
);
  localparam int MD = DIGITS - 1;
  localparam int NB = MD + (WIDTH + 3) / 3;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2;
  localparam logic [6:0] BLANK = 7'b1111111, DASH = 7'b0111111;
  localparam logic [IW-1:0] LAST_I = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_P = PW'(SCAN_DIV - 1);
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [WIDTH:0]    sh, mag_in, ea, eb;
  logic [4*NB-1:0]   bcd, adj;
  logic              neg_c, lz;
  logic [4*MD-1:0]   disp;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;
  logic [6:0]        pat;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction
  assign busy = state != IDLE;
  assign ea = {1'b0, op_a};
  assign eb = {1'b0, op_b};
  assign mag_in = !sub ? ea + eb : ea >= eb ? ea - eb : eb - ea;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NB; i++)
      adj[4*i+:4] = bcd[4*i+:4] > 4'd4 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  // Digit 0 is never blanked, so a zero magnitude still shows a single '0'.
  always_comb begin
    nib = 4'(disp >> (4 * idx));
    lz  = idx != '0 && (disp >> (4 * idx)) == '0;
    pat = ovf ? DASH : idx == LAST_I ? (neg ? DASH : BLANK) : lz ? BLANK : seg7(nib);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      bcd   <= '0;
      neg_c <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      disp  <= '0;
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      sseg  <= BLANK;
    end else begin
      done <= state == DONE;
      if (state == IDLE && start) begin
        state <= CONV;
        cnt   <= '0;
        sh    <= mag_in;
        bcd   <= '0;
        neg_c <= sub && op_a < op_b;
      end
      if (state == CONV) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt       <= cnt + 1'b1;
        if (cnt == CW'(WIDTH)) state <= DONE;
      end
      if (state == DONE) begin
        state <= IDLE;
        disp  <= bcd[4*MD-1:0];
        neg   <= neg_c;
        ovf   <= |bcd[4*NB-1:4*MD];
      end
      presc <= presc == LAST_P ? '0 : presc + 1'b1;
      if (presc == LAST_P) begin
        an   <= ~(DIGITS'(1) << idx);
        sseg <= pat;
        idx  <= idx == LAST_I ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_sseg_scan.sv
// tb_alu_sseg_scan: directed checks of arithmetic, BCD display, overflow, sequencing and digit scan
module tb_alu_sseg_scan;
  localparam logic [6:0] BL = 7'b1111111, DA = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000;
  logic       clk = 0, reset = 1, sub = 0, start = 0;
  logic [7:0] op_a = 0, op_b = 0;
  logic       busy, done, neg, ovf, busy2, done2, neg2, ovf2;
  logic [6:0] sseg, sseg2;
  logic [3:0] an;
  logic [2:0] an2;
  logic [6:0] cap [4];
  logic [6:0] cap2 [3];
  int nvec = 0, nerr = 0, lat;
  alu_sseg_scan #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b), .sub(sub), .start(start),
    .busy(busy), .done(done), .neg(neg), .ovf(ovf), .sseg(sseg), .an(an));
  alu_sseg_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut3 (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b), .sub(sub), .start(start),
    .busy(busy2), .done(done2), .neg(neg2), .ovf(ovf2), .sseg(sseg2), .an(an2));
  always #5 clk = ~clk;
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s);
    op_a = a; op_b = b; sub = s; start = 1;
    @(posedge clk); #1;
    start = 0; op_a = ~a; op_b = ~b; sub = ~s;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask
  task automatic capture;
    for (int i = 0; i < 4; i++) cap[i] = 'x;
    for (int i = 0; i < 3; i++) cap2[i] = 'x;
    repeat (32) @(posedge clk);
    repeat (16) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (!an[i]) cap[i] = sseg;
      for (int i = 0; i < 3; i++) if (!an2[i]) cap2[i] = sseg2;
    end
  endtask
  task automatic test_reset;
    reset = 1; start = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0; start = 0;
    nvec++; if (busy !== 0 || done !== 0) begin nerr++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    nvec++; if (neg !== 0 || ovf !== 0) begin nerr++; $display("FAIL reset_flags got %b%b want 00", neg, ovf); end
    nvec++; if (an !== 4'b1111 || sseg !== BL) begin nerr++; $display("FAIL reset_outputs an=%b sseg=%b want 1111 1111111", an, sseg); end
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, BL, BL, S0}) begin nerr++; $display("FAIL reset_display got %h want %h", {cap[3], cap[2], cap[1], cap[0]}, {BL, BL, BL, S0}); end
  endtask
  task automatic test_add;
    run(8'd200, 8'd100, 0);
    nvec++; if (lat !== 10) begin nerr++; $display("FAIL add_latency got %0d want 10", lat); end
    nvec++; if (busy !== 0) begin nerr++; $display("FAIL add_busy_after got %b want 0", busy); end
    @(posedge clk); #1;
    nvec++; if (done !== 0) begin nerr++; $display("FAIL add_done_width got %b want 0", done); end
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, S3, S0, S0} || neg !== 0 || ovf !== 0) begin nerr++; $display("FAIL add_300 got %h n%b o%b want %h n0 o0", {cap[3], cap[2], cap[1], cap[0]}, neg, ovf, {BL, S3, S0, S0}); end
  endtask
  task automatic test_sub;
    run(8'd5, 8'd205, 1);
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {DA, S2, S0, S0} || neg !== 1 || ovf !== 0) begin nerr++; $display("FAIL sub_neg got %h n%b o%b want %h n1 o0", {cap[3], cap[2], cap[1], cap[0]}, neg, ovf, {DA, S2, S0, S0}); end
    run(8'd205, 8'd5, 1);
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, S2, S0, S0} || neg !== 0) begin nerr++; $display("FAIL sub_pos got %h n%b want %h n0", {cap[3], cap[2], cap[1], cap[0]}, neg, {BL, S2, S0, S0}); end
  endtask
  task automatic test_ovf;
    run(8'd255, 8'd255, 0);
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, S5, S1, S0} || ovf !== 0) begin nerr++; $display("FAIL sum_510 got %h o%b want %h o0", {cap[3], cap[2], cap[1], cap[0]}, ovf, {BL, S5, S1, S0}); end
    nvec++; if ({cap2[2], cap2[1], cap2[0]} !== {DA, DA, DA} || ovf2 !== 1) begin nerr++; $display("FAIL ovf_3digit got %h o%b want %h o1", {cap2[2], cap2[1], cap2[0]}, ovf2, {DA, DA, DA}); end
  endtask
  task automatic test_small;
    run(8'd0, 8'd7, 0);
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, BL, BL, S7}) begin nerr++; $display("FAIL small_7 got %h want %h", {cap[3], cap[2], cap[1], cap[0]}, {BL, BL, BL, S7}); end
    nvec++; if ({cap2[2], cap2[1], cap2[0]} !== {BL, BL, S7} || ovf2 !== 0) begin nerr++; $display("FAIL small_7_3digit got %h o%b want %h o0", {cap2[2], cap2[1], cap2[0]}, ovf2, {BL, BL, S7}); end
    run(8'd9, 8'd9, 1);
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, BL, BL, S0} || neg !== 0) begin nerr++; $display("FAIL equal_sub got %h n%b want %h n0", {cap[3], cap[2], cap[1], cap[0]}, neg, {BL, BL, BL, S0}); end
  endtask
  task automatic test_ignore_start;
    int nd = 0;
    op_a = 8'd5; op_b = 8'd205; sub = 1; start = 1;
    @(posedge clk); #1 start = 0;
    for (int k = 1; k <= 25; k++) begin
      start = (k == 3 || k == 5);
      @(posedge clk); #1 start = 0;
      if (done) nd++;
    end
    nvec++; if (nd !== 1) begin nerr++; $display("FAIL ignore_start dones got %0d want 1", nd); end
    nvec++; if (neg !== 1) begin nerr++; $display("FAIL ignore_start_neg got %b want 1", neg); end
  endtask
  task automatic test_abort;
    int nd = 0;
    op_a = 8'd200; op_b = 8'd100; sub = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) begin @(posedge clk); #1; end
    nvec++; if (busy !== 1) begin nerr++; $display("FAIL abort_busy_mid got %b want 1", busy); end
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    nvec++; if (busy !== 0) begin nerr++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (15) begin @(posedge clk); #1; if (done) nd++; end
    nvec++; if (nd !== 0) begin nerr++; $display("FAIL abort_done got %0d want 0", nd); end
    capture;
    nvec++; if ({cap[3], cap[2], cap[1], cap[0]} !== {BL, BL, BL, S0} || neg !== 0 || ovf !== 0) begin nerr++; $display("FAIL abort_display got %h n%b o%b want %h n0 o0", {cap[3], cap[2], cap[1], cap[0]}, neg, ovf, {BL, BL, BL, S0}); end
  endtask
  task automatic test_back_to_back;
    int nd = 0;
    op_a = 8'd0; op_b = 8'd7; sub = 0; start = 1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (k == 21) start = 0;
    end
    nvec++; if (nd !== 2) begin nerr++; $display("FAIL back_to_back dones got %0d want 2", nd); end
    nvec++; if (busy !== 0) begin nerr++; $display("FAIL back_to_back_idle got %b want 0", busy); end
  endtask
  task automatic test_scan;
    logic [3:0] prev;
    logic       found = 0;
    prev = an;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = prev != 4'b1110 && an == 4'b1110;
      prev = an;
    end
    nvec++; if (!found) begin nerr++; $display("FAIL scan_sync got %b want 1110 edge", an); end
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      nvec++; if (an !== exp_an) begin nerr++; $display("FAIL scan_step%0d got %b want %b", k, an, exp_an); end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_ovf;
    test_small;
    test_ignore_start;
    test_abort;
    test_back_to_back;
    test_scan;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
